// File: rtl/grn_write_arbiter.sv
// rtl/grn_write_arbiter.sv - round-robin arbiter sharing one requestor write path among N_CORES top_grn cores
module grn_write_arbiter #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 512,
    parameter int ID_W    = $clog2(N_CORES),
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       grn_reset,
    input  logic [N_CORES-1:0]         core_enable,
    input  logic [N_CORES-1:0]         req_write_in,
    input  logic [N_CORES*DATA_W-1:0]  transient_in,
    input  logic [N_CORES-1:0]         finish_in,
    output logic [N_CORES-1:0]         ack_write_out,
    output logic                       req_write_out,
    output logic [DATA_W-1:0]          transient_out,
    output logic [ID_W-1:0]            core_id_out,
    input  logic                       ack_write_in,
    output logic                       finish_out,
    output logic [N_CORES*CNT_W-1:0]   write_count
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [N_CORES-1:0]  finish_seen;
    logic [N_CORES-1:0]  eligible;
    logic [N_CORES-1:0]  done;
    logic [DATA_W-1:0]   core_data [N_CORES];
    logic [CNT_W-1:0]    cnt [N_CORES];
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand_idx;
    int                  cand;
    logic [ID_W-1:0]     next_ptr;

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        assign core_data[g]                   = transient_in[g*DATA_W +: DATA_W];
        assign write_count[g*CNT_W +: CNT_W]  = cnt[g];
    end

    assign eligible = req_write_in & core_enable;
    // finish_in counts immediately so finish_out rises the cycle after the last pulse
    assign done     = finish_seen | finish_in | ~core_enable;
    assign next_ptr = (core_id_out == ID_W'(N_CORES - 1)) ? '0 : core_id_out + 1'b1;

    // Walk offsets high to low so the smallest offset from rr_ptr wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_CORES) cand = cand - N_CORES;
            cand_idx = cand[ID_W-1:0];
            if (eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            finish_seen   <= '0;
            finish_out    <= 1'b0;
            req_write_out <= 1'b0;
            ack_write_out <= '0;
            transient_out <= '0;
            core_id_out   <= '0;
            for (int i = 0; i < N_CORES; i++) cnt[i] <= '0;
        end else if (grn_reset) begin
            // Counters survive a grn_reset; only the hard reset clears them
            state         <= IDLE;
            rr_ptr        <= '0;
            finish_seen   <= '0;
            finish_out    <= 1'b0;
            req_write_out <= 1'b0;
            ack_write_out <= '0;
        end else begin
            finish_seen   <= finish_seen | finish_in;
            finish_out    <= (&done) && (state == IDLE) && !(|eligible);
            ack_write_out <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        transient_out <= core_data[grant_idx];
                        core_id_out   <= grant_idx;
                        req_write_out <= 1'b1;
                        state         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_write_in) begin
                        ack_write_out    <= N_CORES'(1) << core_id_out;
                        req_write_out    <= 1'b0;
                        cnt[core_id_out] <= cnt[core_id_out] + CNT_W'(1);
                        rr_ptr           <= next_ptr;
                        state            <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grn_write_arbiter.sv
// tb/tb_grn_write_arbiter.sv - table-driven directed bench for grn_write_arbiter
module tb_grn_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            grn_reset;
    logic [N-1:0]    core_enable;
    logic [N-1:0]    req_write_in;
    logic [N*DW-1:0] transient_in;
    logic [N-1:0]    finish_in;
    logic [N-1:0]    ack_write_out;
    logic            req_write_out;
    logic [DW-1:0]   transient_out;
    logic [1:0]      core_id_out;
    logic            ack_write_in;
    logic            finish_out;
    logic [N*CW-1:0] write_count;

    grn_write_arbiter #(.N_CORES(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .grn_reset(grn_reset), .core_enable(core_enable),
        .req_write_in(req_write_in), .transient_in(transient_in), .finish_in(finish_in),
        .ack_write_out(ack_write_out), .req_write_out(req_write_out),
        .transient_out(transient_out), .core_id_out(core_id_out),
        .ack_write_in(ack_write_in), .finish_out(finish_out), .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en, req, fin;
        logic       ack, grst;
        logic       e_rq;
        logic [1:0] e_id;
        logic [3:0] e_ack;
        logic       e_fin;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt [N];

    function automatic logic [DW-1:0] pat(input int i);
        logic [DW-1:0] p;
        for (int w = 0; w < DW/32; w++) p[w*32 +: 32] = 32'hD000_0000 + 32'(i) * 32'h100 + 32'(w);
        return p;
    endfunction

    function automatic vec_t mk(input logic [3:0] en, req, fin, input logic ack, grst,
                                input logic e_rq, input logic [1:0] e_id,
                                input logic [3:0] e_ack, input logic e_fin);
        vec_t v;
        v.en = en; v.req = req; v.fin = fin; v.ack = ack; v.grst = grst;
        v.e_rq = e_rq; v.e_id = e_id; v.e_ack = e_ack; v.e_fin = e_fin;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        core_enable  = v.en;
        req_write_in = v.req;
        finish_in    = v.fin;
        ack_write_in = v.ack;
        grn_reset    = v.grst;
        @(posedge clk);
        #1;
        chk("req_write_out", idx, DW'(req_write_out), DW'(v.e_rq));
        chk("ack_write_out", idx, DW'(ack_write_out), DW'(v.e_ack));
        chk("finish_out",    idx, DW'(finish_out),    DW'(v.e_fin));
        if (v.e_rq) begin
            chk("core_id_out",   idx, DW'(core_id_out), DW'(v.e_id));
            chk("transient_out", idx, transient_out, pat(int'(v.e_id)));
        end
        for (int i = 0; i < N; i++) if (v.e_ack[i]) exp_cnt[i]++;
    endtask

    task automatic chk_counts(input int idx);
        for (int i = 0; i < N; i++)
            chk("write_count", idx * 10 + i, DW'(write_count[i*CW +: CW]), DW'(exp_cnt[i]));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            transient_in[i*DW +: DW] = pat(i);
            exp_cnt[i] = 0;
        end
        reset = 1'b1; grn_reset = 1'b0; core_enable = '0; req_write_in = '0;
        finish_in = '0; ack_write_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req",   0, DW'(req_write_out), '0);
        chk("reset_ack",   0, DW'(ack_write_out), '0);
        chk("reset_fin",   0, DW'(finish_out),    '0);
        chk("reset_id",    0, DW'(core_id_out),   '0);
        chk("reset_data",  0, transient_out,      '0);
        chk_counts(0);
        reset = 1'b0;

        // single core 2 grant, then rr_ptr=3 and wrap
        tbl.push_back(mk(4'b1111, 4'b0100, 4'b0000, 0, 0, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0100, 4'b0000, 0, 0, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0100, 4'b0000, 0, 0, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0100, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 3, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b1000, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        // stale request from core 1 during RELEASE, core 2 wins next
        tbl.push_back(mk(4'b1111, 4'b0010, 4'b0000, 0, 0, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(mk(4'b1111, 4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0110, 4'b0000, 0, 0, 1, 2, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0110, 4'b0000, 1, 0, 0, 0, 4'b0100, 0));
        // stray acks outside WAIT_ACK
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
        // masking with core_enable=1010
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 0, 0, 1, 3, 4'b0000, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b1000, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 0, 0, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 0, 0, 1, 3, 4'b0000, 0));
        tbl.push_back(mk(4'b1010, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b1000, 0));
        tbl.push_back(mk(4'b1010, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        // granted core disabled mid-WAIT_ACK, then all-disabled finish
        tbl.push_back(mk(4'b1111, 4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 1));
        // finish pulses on 0,1,3 with core 2 disabled
        tbl.push_back(mk(4'b1011, 4'b0000, 4'b0001, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1011, 4'b0000, 4'b0010, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1011, 4'b0000, 4'b1000, 0, 0, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(4'b1011, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(4'b1011, 4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
        // grn_reset coincident with ack: dropped, rr_ptr back to 0
        tbl.push_back(mk(4'b1011, 4'b0001, 4'b0000, 1, 1, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1011, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);
        chk_counts(1);

        // fairness: all cores requesting, ack two cycles after each grant
        for (int k = 0; k < 8; k++) begin
            apply(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 2'(k % 4), 4'b0000, 0), 100 + k);
            apply(mk(4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'(1 << (k % 4)), 0), 100 + k);
            apply(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 4'b0000, 0), 100 + k);
            apply(mk(4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 2'((k + 1) % 4), 4'b0000, 0), 100 + k);
        end
        chk_counts(2);

        // asynchronous reset while a grant is pending
        #3 reset = 1'b1;
        #1;
        chk("async_req", 200, DW'(req_write_out), '0);
        chk("async_id",  200, DW'(core_id_out),   '0);
        chk("async_data", 200, transient_out,     '0);
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        chk_counts(3);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
